// File: rtl/dot_pkg.sv
// -----------------------------------------------------------------------------
// dot_pkg
// Shared constants and state encoding for the dot-product operand loader.
//   DOT_N  : operand pairs per frame
//   DOT_W  : operand width
//   DOT_PW : result width
//   dot_state_e : loader FSM states (LOAD, SETTLE, HOLD)
// -----------------------------------------------------------------------------
package dot_pkg;

    localparam int DOT_N  = 10;
    localparam int DOT_W  = 4;
    localparam int DOT_PW = 16;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } dot_state_e;

endpackage

// File: rtl/dot_operand_loader_if.sv
// -----------------------------------------------------------------------------
// dot_operand_loader_if
// Bundles the operand stream, the parallel operand buses, the dot-product
// result input and the result stream of dot_operand_loader.
//   in_valid/in_ready/in_x/in_y       : operand beat stream
//   x_bus/y_bus                       : parallel operands, slot k at [k*W +: W]
//   p_in                              : P from the dot-product unit
//   res_valid/res_ready/res_data/res_err : result stream
// Modports:
//   slave  : the loader
//   master : the environment (operand source, dot-product unit, result sink)
// -----------------------------------------------------------------------------
interface dot_operand_loader_if
    import dot_pkg::*;
#(
    parameter int N  = DOT_N,
    parameter int W  = DOT_W,
    parameter int PW = DOT_PW
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_x;
    logic [W-1:0]    in_y;
    logic [N*W-1:0]  x_bus;
    logic [N*W-1:0]  y_bus;
    logic [PW-1:0]   p_in;
    logic            res_valid;
    logic            res_ready;
    logic [PW-1:0]   res_data;
    logic            res_err;

    modport slave (
        input  in_valid, in_x, in_y, p_in, res_ready,
        output in_ready, x_bus, y_bus, res_valid, res_data, res_err
    );

    modport master (
        output in_valid, in_x, in_y, p_in, res_ready,
        input  in_ready, x_bus, y_bus, res_valid, res_data, res_err
    );

endinterface

// File: rtl/dot_selfcheck_acc.sv
// -----------------------------------------------------------------------------
// dot_selfcheck_acc
// Running sum of x*y over the accepted beats of a frame, compared against the
// P value returned by the dot-product unit.
//   clk, rst  : clock, synchronous active-high reset
//   beat      : an operand beat is accepted this cycle
//   first     : the accepted beat is slot 0 of a frame
//   x, y      : operands of the beat
//   p_in      : P from the dot-product unit
//   mismatch  : p_in differs from the accumulated sum
// -----------------------------------------------------------------------------
module dot_selfcheck_acc
    import dot_pkg::*;
#(
    parameter int W  = DOT_W,
    parameter int PW = DOT_PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beat,
    input  logic          first,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    input  logic [PW-1:0] p_in,
    output logic          mismatch
);

    logic [PW-1:0] acc;
    logic [PW-1:0] prod;

    assign prod = PW'(x) * PW'(y);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (beat) begin
            // the first beat restarts the sum rather than clearing a cycle early
            acc <= first ? prod : acc + prod;
        end
    end

    assign mismatch = (p_in != acc);

endmodule

// File: rtl/dot_operand_loader.sv
// -----------------------------------------------------------------------------
// dot_operand_loader
// Collects N (x, y) operand beats into the parallel X/Y buses of the 10-term
// dot-product unit, holds them stable for LAT cycles, captures P and offers it
// on a valid/ready result port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dot_operand_loader_if.slave (operand stream, buses, p_in,
//              result stream)
// Build option: DOT_LOADER_SELFCHECK_EN adds an accumulator that recomputes
// the dot product and flags res_err when p_in disagrees; otherwise res_err = 0.
//
// state  | meaning
// LOAD   | accepting operand beats into slot cnt
// SETTLE | buses frozen, counting LAT cycles for the unit to settle
// HOLD   | result presented until res_ready
// -----------------------------------------------------------------------------
module dot_operand_loader
    import dot_pkg::*;
#(
    parameter int N   = DOT_N,
    parameter int W   = DOT_W,
    parameter int PW  = DOT_PW,
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    dot_operand_loader_if.slave bus
);

    localparam logic [1:0] ST_LOAD   = LOAD;
    localparam logic [1:0] ST_SETTLE = SETTLE;
    localparam logic [1:0] ST_HOLD   = HOLD;

    localparam int CW = (N   > 1) ? $clog2(N)   : 1;
    localparam int WW = (LAT > 1) ? $clog2(LAT) : 1;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [WW-1:0]   wait_cnt;
    logic [N*W-1:0]  x_q;
    logic [N*W-1:0]  y_q;
    logic [PW-1:0]   res_data_q;
    logic            beat;
    logic            capture;

    assign beat    = (state == ST_LOAD) && bus.in_valid;
    assign capture = (state == ST_SETTLE) && (wait_cnt == WW'(LAT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            cnt        <= '0;
            wait_cnt   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            res_data_q <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        x_q[int'(cnt)*W +: W] <= bus.in_x;
                        y_q[int'(cnt)*W +: W] <= bus.in_y;
                        if (cnt == CW'(N - 1)) begin
                            cnt      <= '0;
                            wait_cnt <= '0;
                            state    <= ST_SETTLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    wait_cnt <= wait_cnt + WW'(1);
                    if (capture) begin
                        res_data_q <= bus.p_in;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_LOAD);
    assign bus.res_valid = (state == ST_HOLD);
    assign bus.res_data  = res_data_q;
    assign bus.x_bus     = x_q;
    assign bus.y_bus     = y_q;

`ifdef DOT_LOADER_SELFCHECK_EN
    logic mismatch;
    logic res_err_q;

    dot_selfcheck_acc #(
        .W  (W),
        .PW (PW)
    ) u_selfcheck (
        .clk      (clk),
        .rst      (rst),
        .beat     (beat),
        .first    (cnt == '0),
        .x        (bus.in_x),
        .y        (bus.in_y),
        .p_in     (bus.p_in),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            res_err_q <= 1'b0;
        end else if (capture) begin
            res_err_q <= mismatch;
        end
    end

    assign bus.res_err = res_err_q;
`else
    logic unused_beat;
    assign unused_beat = beat;
    assign bus.res_err = 1'b0;
`endif

endmodule

// File: tb/tb_dot_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_dot_operand_loader
// Directed bench for dot_operand_loader. Inputs change on the falling edge,
// outputs are sampled on the falling edge. p_in is produced by a behavioural
// dot-product unit summing x_bus*y_bus, with an optional offset to corrupt it.
// Build option DOT_LOADER_SELFCHECK_EN enables the res_err scenarios.
// -----------------------------------------------------------------------------
module tb_dot_operand_loader;
    import dot_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] p_off;
    logic [15:0] psum;
    logic [3:0]  fx [10];
    logic [3:0]  fy [10];
    int checks   = 0;
    int failures = 0;

    dot_operand_loader_if bus_if ();

    dot_operand_loader u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always_comb begin
        psum = 16'd0;
        for (int k = 0; k < 10; k++) begin
            psum = psum + 16'(bus_if.x_bus[k*4 +: 4]) * 16'(bus_if.y_bus[k*4 +: 4]);
        end
        bus_if.p_in = psum + p_off;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input bit bubble);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus_if.in_valid = 1'b1;
            bus_if.in_x     = fx[i];
            bus_if.in_y     = fy[i];
            if (bubble) begin
                @(negedge clk);
                bus_if.in_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (!bus_if.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 64'(bus_if.res_valid), 64'd1);
    endtask

    // expects res_ready high: handshake completes at the next rising edge
    task automatic check_result(input string tag, input logic [15:0] exp_data, input logic exp_err);
        wait_result(tag);
        chk({tag, "_data"}, 64'(bus_if.res_data), 64'(exp_data));
        chk({tag, "_err"},  64'(bus_if.res_err),  64'(exp_err));
        @(negedge clk);
        chk({tag, "_rdy_after"}, 64'(bus_if.in_ready),  64'd1);
        chk({tag, "_rv_after"},  64'(bus_if.res_valid), 64'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"},  64'(bus_if.in_ready),  64'd1);
        chk({tag, "_res_valid"}, 64'(bus_if.res_valid), 64'd0);
        chk({tag, "_res_data"},  64'(bus_if.res_data),  64'd0);
        chk({tag, "_res_err"},   64'(bus_if.res_err),   64'd0);
        chk({tag, "_x_bus"},     64'(bus_if.x_bus),     64'd0);
        chk({tag, "_y_bus"},     64'(bus_if.y_bus),     64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        p_off            = 16'd0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_x      = 4'd0;
        bus_if.in_y      = 4'd0;
        bus_if.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;

        // back-to-back ones: latency and throughput
        for (int i = 0; i < 10; i++) begin fx[i] = 4'd1; fy[i] = 4'd1; end
        send_frame(1'b0);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        chk("lat1_rv", 64'(bus_if.res_valid), 64'd0);
        chk("lat1_rdy", 64'(bus_if.in_ready), 64'd0);
        @(negedge clk);
        chk("lat2_rv", 64'(bus_if.res_valid), 64'd0);
        @(negedge clk);
        chk("lat3_rv", 64'(bus_if.res_valid), 64'd1);
        chk("ones_data", 64'(bus_if.res_data), 64'd10);
        chk("ones_err", 64'(bus_if.res_err), 64'd0);
        chk("ones_rdy_hold", 64'(bus_if.in_ready), 64'd0);
        @(negedge clk);
        chk("ones_rdy_after", 64'(bus_if.in_ready), 64'd1);
        chk("ones_rv_after", 64'(bus_if.res_valid), 64'd0);

        // maximum operands
        for (int i = 0; i < 10; i++) begin fx[i] = 4'd15; fy[i] = 4'd15; end
        send_frame(1'b0);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        check_result("max", 16'd2250, 1'b0);

        // x=k, y=9-k
        for (int i = 0; i < 10; i++) begin fx[i] = 4'(i); fy[i] = 4'(9 - i); end
        send_frame(1'b0);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        chk("ramp_x_bus", 64'(bus_if.x_bus), 64'h98_7654_3210);
        chk("ramp_y_bus", 64'(bus_if.y_bus), 64'h01_2345_6789);
        check_result("ramp", 16'd120, 1'b0);

        // bubble on every other cycle
        for (int i = 0; i < 10; i++) begin fx[i] = 4'(i + 1); fy[i] = 4'd2; end
        send_frame(1'b1);
        wait_result("bub");
        chk("bub_x_bus", 64'(bus_if.x_bus), 64'hA9_8765_4321);
        chk("bub_slot3", 64'(bus_if.x_bus[15:12]), 64'd4);
        chk("bub_y_bus", 64'(bus_if.y_bus), 64'h22_2222_2222);
        check_result("bub", 16'd110, 1'b0);

        // result stalled in HOLD with extra beats offered
        bus_if.res_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin fx[i] = 4'(i); fy[i] = 4'd1; end
        send_frame(1'b0);
        @(negedge clk);
        bus_if.in_x = 4'd15;
        bus_if.in_y = 4'd15;
        wait_result("stall");
        chk("stall_data0", 64'(bus_if.res_data), 64'd45);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_rv",    64'(bus_if.res_valid), 64'd1);
            chk("stall_data",  64'(bus_if.res_data),  64'd45);
            chk("stall_rdy",   64'(bus_if.in_ready),  64'd0);
            chk("stall_x_bus", 64'(bus_if.x_bus),     64'h98_7654_3210);
        end
        bus_if.res_ready = 1'b1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        chk("hs_rdy", 64'(bus_if.in_ready), 64'd1);
        chk("hs_rv",  64'(bus_if.res_valid), 64'd0);
        chk("hs_no_beat", 64'(bus_if.x_bus), 64'h98_7654_3210);

        // reset mid-frame
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_if.in_valid = 1'b1;
            bus_if.in_x     = 4'd3;
            bus_if.in_y     = 4'd3;
        end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        chk("pre_rst_slot3", 64'(bus_if.x_bus[15:12]), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("rst1");
        for (int i = 0; i < 10; i++) begin fx[i] = 4'd1; fy[i] = 4'd2; end
        send_frame(1'b0);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        chk("rst_frame_x_bus", 64'(bus_if.x_bus), 64'h11_1111_1111);
        check_result("rst_frame", 16'd20, 1'b0);

`ifdef DOT_LOADER_SELFCHECK_EN
        // corrupted P must be flagged, clean P must not
        for (int i = 0; i < 10; i++) begin fx[i] = 4'd1; fy[i] = 4'd1; end
        p_off = 16'd1;
        send_frame(1'b0);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        check_result("sc_bad", 16'd11, 1'b1);
        p_off = 16'd0;
        for (int i = 0; i < 10; i++) begin fx[i] = 4'(i); fy[i] = 4'(9 - i); end
        send_frame(1'b0);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        check_result("sc_good", 16'd120, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
